// File: rtl/unit_input_dispatch_pkg.sv
// Shared definitions for the unit input dispatcher: bus width, packet type
// codes, FSM state encoding and the index-width helper.
// ENTRY_PTS_EN adds the broadcast state used for entry-point packets.
package unit_input_dispatch_pkg;

  localparam int UNIT_INPUT_WIDTH = 32;

  localparam logic [2:0] PKT_TYPE_DATA     = 3'd0;
  localparam logic [2:0] PKT_TYPE_ENTRY_PT = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_SELECT = 3'd2,
    ST_SEND   = 3'd3,
    ST_DROP   = 3'd4
`ifdef ENTRY_PTS_EN
    ,
    ST_BCAST  = 3'd5
`endif
  } state_t;

  // Index of the highest set bit; msb(N-1) gives the top bit of a unit index.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/unit_input_dispatch_if.sv
// Bundle between the upstream FWFT FIFO, the dispatcher and the unit inputs.
// Upstream: in/in_ctrl/in_empty in, in_rd_en back. Downstream: shared
// out/out_ctrl, per-unit out_wr_en, unit_afull and unit_ready back.
interface unit_input_dispatch_if import unit_input_dispatch_pkg::*; #(
  parameter int N_UNITS     = 4,
  parameter int INPUT_WIDTH = UNIT_INPUT_WIDTH
);

  logic [INPUT_WIDTH-1:0] in;
  logic                   in_ctrl;
  logic                   in_empty;
  logic                   in_rd_en;
  logic [INPUT_WIDTH-1:0] out;
  logic                   out_ctrl;
  logic [N_UNITS-1:0]     out_wr_en;
  logic [N_UNITS-1:0]     unit_afull;
  logic [N_UNITS-1:0]     unit_ready;

  // master: the dispatcher; slave: the FIFO/unit side that feeds and sinks it
  modport master (
    input  in, in_ctrl, in_empty, unit_afull, unit_ready,
    output in_rd_en, out, out_ctrl, out_wr_en
  );

  modport slave (
    output in, in_ctrl, in_empty, unit_afull, unit_ready,
    input  in_rd_en, out, out_ctrl, out_wr_en
  );

endinterface

// File: rtl/unit_input_dispatch_rr_select.sv
// Rotating-priority pick: first set bit of eligible after index last, wrapping.
// Purely combinational, 0 cycles; no backpressure.
// Ports: eligible (N bits), last (index) in; found, idx out.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // i = N wraps back to last itself, so a lone eligible last unit still wins
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last) + i) % N);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/unit_input_dispatch.sv
// Dispatches whole packets from one FWFT stream to ready, idle units, round-robin.
// Latency: in_rd_en combinational, out/out_wr_en registered one cycle after the read.
// Backpressure: stalls on in_empty or unit_afull (cur unit, or any unit when broadcasting).
// Ports: CLK, RST_N (async active-low); bus (master modport): upstream in/in_ctrl/
// in_empty -> in_rd_en, downstream out/out_ctrl/out_wr_en, unit_afull/unit_ready;
// err_stray: sticky, a data word arrived outside any packet.
// ENTRY_PTS_EN: broadcast type-1 packets to all units; undefined, they are dropped.
module unit_input_dispatch import unit_input_dispatch_pkg::*; #(
  parameter int N_UNITS     = 4,
  parameter int UNITS_MSB   = msb(N_UNITS - 1),
  parameter int INPUT_WIDTH = UNIT_INPUT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  unit_input_dispatch_if.master bus,
  output logic                  err_stray
);

  localparam int IW = UNITS_MSB + 1;

  state_t             state, state_nxt;
  logic [IW-1:0]      cur_unit, last_unit, sel_idx;
  logic               sel_found;
  logic [N_UNITS-1:0] pending, eligible, wr_mask, pend_set;
  logic               hdr_done;  // header of the packet in flight already consumed
  logic               rd, set_pend, stray, latch_sel, term;

  assign eligible = bus.unit_ready & ~pending;
  // a ctrl word read after the header closes the packet
  assign term     = rd & hdr_done & bus.in_ctrl;
  assign pend_set = set_pend ? wr_mask : '0;

  rr_select #(.N(N_UNITS), .W(IW)) u_rr (
    .eligible (eligible),
    .last     (last_unit),
    .found    (sel_found),
    .idx      (sel_idx)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr_mask   = '0;
    set_pend  = 1'b0;
    stray     = 1'b0;
    latch_sel = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.in_empty) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (bus.in_empty) begin
          state_nxt = ST_IDLE;
        end else if (!bus.in_ctrl) begin
          rd    = 1'b1;
          stray = 1'b1;
        end else if (bus.in[2:0] == PKT_TYPE_DATA) begin
          state_nxt = ST_SELECT;
`ifdef ENTRY_PTS_EN
        end else if (bus.in[2:0] == PKT_TYPE_ENTRY_PT) begin
          state_nxt = ST_BCAST;
`endif
        end else begin
          state_nxt = ST_DROP;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          latch_sel = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        rd = !bus.in_empty && !bus.unit_afull[cur_unit];
        if (rd) begin
          wr_mask  = {{(N_UNITS-1){1'b0}}, 1'b1} << cur_unit;
          set_pend = !hdr_done;
        end
        if (term) state_nxt = ST_IDLE;
      end
`ifdef ENTRY_PTS_EN
      ST_BCAST: begin
        rd = !bus.in_empty && !(|bus.unit_afull);
        if (rd) wr_mask = '1;
        if (term) state_nxt = ST_IDLE;
      end
`endif
      ST_DROP: begin
        rd = !bus.in_empty;
        if (term) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_rd_en = rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_unit      <= '0;
      last_unit     <= IW'(N_UNITS - 1);
      hdr_done      <= 1'b0;
      pending       <= '0;
      err_stray     <= 1'b0;
      bus.out       <= '0;
      bus.out_ctrl  <= 1'b0;
      bus.out_wr_en <= '0;
    end else begin
      if (latch_sel) begin
        cur_unit  <= sel_idx;
        last_unit <= sel_idx;
      end
      // HDR never consumes the header itself, so the next read after it is the header
      if (state == ST_HDR) hdr_done <= 1'b0;
      else if (rd)         hdr_done <= 1'b1;
      // set beats a same-cycle ready drop
      pending       <= pend_set | (pending & bus.unit_ready);
      err_stray     <= err_stray | stray;
      bus.out_wr_en <= wr_mask;
      if (|wr_mask) begin
        bus.out      <= bus.in;
        bus.out_ctrl <= bus.in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_unit_input_dispatch.sv
module tb_unit_input_dispatch;

  logic CLK = 1'b0;
  logic RST_N;
  logic err_stray;

  always #5 CLK = ~CLK;

  unit_input_dispatch_if #(.N_UNITS(4), .INPUT_WIDTH(32)) bus ();

  unit_input_dispatch #(.N_UNITS(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .err_stray (err_stray)
  );

  int n_chk = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic rd_s;

  logic [32:0] fifo [$];   // {ctrl, data} upstream words
  logic [36:0] wr_q [$];   // {wr_en, ctrl, data} observed writes
  logic [3:0]  hdr_q [$];  // wr_en of each header write

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.in_empty = (fifo.size() == 0);
    if (fifo.size() > 0) {bus.in_ctrl, bus.in} = fifo[0];
    else                 {bus.in_ctrl, bus.in} = '0;
  endtask

  // one clock: sample rd at negedge, let the DUT consume, then pop our FIFO model
  task automatic tick();
    @(negedge CLK);
    rd_s = bus.in_rd_en;
    if (rd_s) rd_cnt++;
    @(posedge CLK);
    #1;
    if (rd_s && fifo.size() > 0) void'(fifo.pop_front());
    drive();
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && |bus.out_wr_en) begin
      wr_q.push_back({bus.out_wr_en, bus.out_ctrl, bus.out});
      if (bus.out_ctrl && bus.out[31:16] == 16'h0000) hdr_q.push_back(bus.out_wr_en);
    end
  end

  function automatic logic [32:0] pw(input logic [2:0] ty, input logic [7:0] tg, input int n, input int k);
    if (k == 0)     return {1'b1, 16'h0000, tg, 5'b0, ty};
    if (k == n + 1) return {1'b1, 16'hFFFF, 8'h00, tg};
    return {1'b0, 8'hDA, tg, 16'(k)};
  endfunction

  task automatic push_pkt(input logic [2:0] ty, input logic [7:0] tg, input int n);
    for (int k = 0; k <= n + 1; k++) fifo.push_back(pw(ty, tg, n, k));
    drive();
  endtask

  function automatic int cnt(input int u);
    int c = 0;
    foreach (wr_q[i]) if (wr_q[i][33+u]) c++;
    return c;
  endfunction

  function automatic logic [32:0] wword(input int u, input int k);
    int c = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i][33+u]) begin
        if (c == k) return wr_q[i][32:0];
        c++;
      end
    end
    return '0;
  endfunction

  task automatic check_pkt(input string tag, input int u, input int start,
                           input logic [2:0] ty, input logic [7:0] tg, input int n);
    for (int k = 0; k <= n + 1; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(wword(u, start + k)), 64'(pw(ty, tg, n, k)));
  endtask

  task automatic run_until(input int u, input int n, input int budget);
    for (int i = 0; i < budget && cnt(u) < n; i++) tick();
  endtask

  task automatic clear_pending();
    bus.unit_ready = 4'b0000;
    tick();
    bus.unit_ready = 4'b1111;
    tick();
  endtask

  function automatic logic [3:0] hdr_at(input int i);
    if (i < hdr_q.size()) return hdr_q[i];
    return 4'h0;
  endfunction

  initial begin
    int r0, w0;
    RST_N = 1'b0;
    bus.unit_ready = 4'b1111;
    bus.unit_afull = 4'b0000;
    drive();
    repeat (3) tick();
    chk("rst_out", 64'(bus.out), 64'h0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'h0);
    chk("rst_wr_en", 64'(bus.out_wr_en), 64'h0);
    chk("rst_err_stray", 64'(err_stray), 64'h0);
    chk("rst_last_unit", 64'(dut.last_unit), 64'h3);
    RST_N = 1'b1;
    tick();

    // 1: single 6-word data packet -> unit 0
    push_pkt(3'd0, 8'h00, 4);
    run_until(0, 6, 60);
    repeat (3) tick();
    chk("t1_cnt_u0", 64'(cnt(0)), 64'd6);
    chk("t1_total", 64'(wr_q.size()), 64'd6);
    check_pkt("t1", 0, 0, 3'd0, 8'h00, 4);
    chk("t1_pending", 64'(dut.pending), 64'h1);

    // 2: four back-to-back packets rotate 1,2,3,0; a fifth waits for a ready drop
    clear_pending();
    wr_q.delete(); hdr_q.delete();
    for (int p = 0; p < 4; p++) push_pkt(3'd0, 8'(8'h10 + p), 2);
    for (int i = 0; i < 200 && wr_q.size() < 16; i++) tick();
    chk("t2_dest0", 64'(hdr_at(0)), 64'h2);
    chk("t2_dest1", 64'(hdr_at(1)), 64'h4);
    chk("t2_dest2", 64'(hdr_at(2)), 64'h8);
    chk("t2_dest3", 64'(hdr_at(3)), 64'h1);
    check_pkt("t2_u3", 3, 0, 3'd0, 8'h12, 2);
    push_pkt(3'd0, 8'h14, 2);
    repeat (10) tick();
    chk("t2_blocked", 64'(hdr_q.size()), 64'd4);
    bus.unit_ready = 4'b1110;
    tick();
    bus.unit_ready = 4'b1111;
    for (int i = 0; i < 40 && wr_q.size() < 20; i++) tick();
    chk("t2_dest4", 64'(hdr_at(4)), 64'h1);

    // 3: afull on the current unit for 10 cycles mid-packet
    clear_pending();
    wr_q.delete(); hdr_q.delete();
    push_pkt(3'd0, 8'h20, 8);
    run_until(1, 3, 40);
    bus.unit_afull = 4'b0010;
    r0 = rd_cnt;
    tick();
    w0 = cnt(1);
    repeat (9) tick();
    chk("t3_no_rd", 64'(rd_cnt - r0), 64'd0);
    chk("t3_no_wr", 64'(cnt(1) - w0), 64'd0);
    bus.unit_afull = 4'b0000;
    run_until(1, 10, 60);
    repeat (3) tick();
    chk("t3_cnt", 64'(cnt(1)), 64'd10);
    check_pkt("t3", 1, 0, 3'd0, 8'h20, 8);

    // 4: entry-point packet followed by a data packet
    clear_pending();
    wr_q.delete(); hdr_q.delete();
    push_pkt(3'd1, 8'h30, 2);
    push_pkt(3'd0, 8'h31, 2);
`ifdef ENTRY_PTS_EN
    run_until(2, 8, 80);
    repeat (3) tick();
    chk("t4_bcast_wen", 64'(hdr_at(0)), 64'hF);
    chk("t4_cnt_u0", 64'(cnt(0)), 64'd4);
    chk("t4_cnt_u3", 64'(cnt(3)), 64'd4);
    check_pkt("t4_bc", 0, 0, 3'd1, 8'h30, 2);
    check_pkt("t4_data", 2, 4, 3'd0, 8'h31, 2);
    chk("t4_data_wen", 64'(hdr_at(1)), 64'h4);
`else
    run_until(2, 4, 80);
    repeat (3) tick();
    chk("t4_cnt_u0", 64'(cnt(0)), 64'd0);
    chk("t4_cnt_u1", 64'(cnt(1)), 64'd0);
    chk("t4_cnt_u3", 64'(cnt(3)), 64'd0);
    chk("t4_cnt_u2", 64'(cnt(2)), 64'd4);
    check_pkt("t4_data", 2, 0, 3'd0, 8'h31, 2);
    chk("t4_hdrs", 64'(hdr_q.size()), 64'd1);
`endif
    chk("t4_fifo_drained", 64'(fifo.size()), 64'd0);
    chk("t4_no_stray", 64'(err_stray), 64'h0);

    // 5: two stray data words, then normal dispatch; flag is sticky
    clear_pending();
    wr_q.delete(); hdr_q.delete();
    fifo.push_back({1'b0, 32'h5757_0001});
    fifo.push_back({1'b0, 32'h5757_0002});
    push_pkt(3'd0, 8'h40, 1);
    run_until(3, 3, 60);
    repeat (3) tick();
    chk("t5_stray", 64'(err_stray), 64'h1);
    chk("t5_cnt_u3", 64'(cnt(3)), 64'd3);
    check_pkt("t5", 3, 0, 3'd0, 8'h40, 1);
    push_pkt(3'd0, 8'h41, 1);
    run_until(0, 3, 60);
    repeat (3) tick();
    chk("t5_next_u0", 64'(cnt(0)), 64'd3);
    chk("t5_stray_sticky", 64'(err_stray), 64'h1);

    // 6: no unit ready -> wait in SELECT; unit 2 alone becomes ready
    wr_q.delete(); hdr_q.delete();
    bus.unit_ready = 4'b0000;
    push_pkt(3'd0, 8'h50, 2);
    r0 = rd_cnt;
    repeat (10) tick();
    chk("t6_no_rd", 64'(rd_cnt - r0), 64'd0);
    chk("t6_no_wr", 64'(wr_q.size()), 64'd0);
    bus.unit_ready = 4'b0100;
    r0 = rd_cnt;
    repeat (2) tick();
    chk("t6_rd_2cyc", 64'(rd_cnt > r0), 64'd1);
    run_until(2, 4, 40);
    repeat (3) tick();
    chk("t6_wen", 64'(hdr_at(0)), 64'h4);
    check_pkt("t6", 2, 0, 3'd0, 8'h50, 2);

    // reset clears sticky flag and pending
    RST_N = 1'b0;
    tick();
    chk("rst2_stray", 64'(err_stray), 64'h0);
    chk("rst2_pending", 64'(dut.pending), 64'h0);
    chk("rst2_wr_en", 64'(bus.out_wr_en), 64'h0);
    RST_N = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/unit_input_dispatch.md
# unit_input_dispatch

Distributes a single upstream packet stream across N_UNITS unit_input blocks. Each data packet goes whole to one ready, idle unit, chosen round-robin. Entry-point packets are broadcast to all units when compiled in. The block sits between the global input FIFO and the per-unit input buses, holds no packet storage, and throttles on each unit's `afull`.

## Interface
Parameters:
- N_UNITS, 4, number of downstream units; 2..16.
- UNITS_MSB, `MSB(N_UNITS-1), index width.
- INPUT_WIDTH, `UNIT_INPUT_WIDTH, word width, same as the unit input bus.

Ports:
- CLK  in  1  single clock.
- RST_N  in  1  reset, asynchronous, active-low.
- in  in  INPUT_WIDTH  upstream word; first-word-fall-through.
- in_ctrl  in  1  framing flag for `in`.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  consume `in`; combinational.
- out  out  INPUT_WIDTH  registered word to units; shared bus.
- out_ctrl  out  1  registered framing flag.
- out_wr_en  out  N_UNITS  registered per-unit write strobe.
- unit_afull  in  N_UNITS  per-unit almost-full.
- unit_ready  in  N_UNITS  per-unit "idle thread available".
- err_stray  out  1  sticky flag: a data word was seen outside any packet.

## Operation
- Framing: a header word has ctrl=1 and carries the type in [2:0]. Data words have ctrl=0. The terminator is the next ctrl=1 word. Type 0 is data; type 1 is entry point.
- pending[N_UNITS]:
  - The bit for a unit is set when a header is written to it.
  - The bit is cleared on any cycle where that unit's unit_ready is 0.
  - A unit is eligible when unit_ready=1 and pending=0.
- FSM states:
  - IDLE: if ~in_empty, go to HDR.
  - HDR: `in` is not consumed.
    - ctrl=1 and type 0: go to SELECT.
    - ctrl=1 and type 1: go to BCAST (ENTRY_PTS_EN), otherwise go to DROP.
    - ctrl=0: consume the word, set err_stray, stay in HDR. If in_empty, go to IDLE.
    - ctrl=1 with any other type: go to DROP.
  - SELECT:
    - Rotating priority search starting at last_unit+1 with wrap-around, 1 cycle.
    - If an eligible unit is found: latch it into cur_unit and last_unit, go to SEND.
    - If none is found: stay in SELECT and retry every cycle.
  - SEND: in_rd_en = ~in_empty & ~unit_afull[cur_unit]. Each consumed word is registered to out/out_ctrl with out_wr_en = one-hot(cur_unit).
    - The first consumed word is the header and sets pending[cur_unit].
    - The first consumed ctrl=1 word after the header is the terminator: go to IDLE.
  - BCAST: in_rd_en = ~in_empty & ~|unit_afull, out_wr_en = all ones, otherwise same as SEND. pending is not touched.
  - DROP: consume words with no write until the terminator has been consumed, then go to IDLE.
- Reset mid-packet: the FSM returns to IDLE, pending clears, and the remainder of the upstream packet is subsequently treated as stray words.

## Timing
- Reset values:
  - out = 0, out_ctrl = 0, out_wr_en = 0, err_stray = 0.
  - pending = 0.
  - last_unit = N_UNITS-1, so that unit 0 wins first.
  - State is IDLE.
- Latency:
  - Header visible to HDR the cycle after IDLE sees ~in_empty.
  - HDR to SELECT: 1 cycle. SELECT to SEND: 1 cycle when a unit is eligible.
  - Each out_wr_en pulse is asserted the cycle after its in_rd_en.
- Throughput: 1 word per cycle in SEND or BCAST while not afull.
- unit_afull is sampled combinationally, and the unit FIFO slack absorbs the 1-cycle output register.
- Simultaneous pending set and unit_ready=0 on the same cycle: set wins.
- in_empty mid-packet: stall with out_wr_en=0 and no state change.

## Configuration
- ENTRY_PTS_EN defined: type-1 packets are broadcast to every unit via BCAST.
- ENTRY_PTS_EN undefined: type-1 packets are consumed in DROP and never forwarded. The BCAST state and its logic are absent.

## Structure
- Packet type codes (PKT_TYPE_DATA=0, PKT_TYPE_ENTRY_PT=1) and the FSM state encodings belong in the shared header alongside `UNIT_INPUT_WIDTH.
- The rotating priority search is one sub-module, rr_select: it takes an N-bit eligible vector and the last index, and returns a found flag and an index.

## Test plan
- Reset, then a 6-word type-0 packet (hdr 0x0000, 4 data, term) with all units ready → unit 0 receives exactly 6 writes, out_ctrl=1 on words 1 and 6; pending[0] is set.
- Four back-to-back type-0 packets, with units ready toggling 1→0→1 per packet → destinations are 0,1,2,3 in order. A fifth packet goes to unit 0 only after its ready has dropped and recovered.
- unit_afull[cur_unit] asserted for 10 cycles mid-packet → in_rd_en=0 and no writes for those 10 cycles; words resume with none lost or duplicated.
- Type-1 packet with ENTRY_PTS_EN → every word is written with out_wr_en=all ones. Without the macro → zero writes, and the following type-0 packet is still delivered intact.
- Two ctrl=0 words before a header → err_stray=1 and remains set until reset; the next packet is dispatched normally.
- All unit_ready=0 → stays in SELECT with no reads. Raising unit_ready[2] → dispatch to unit 2 within 2 cycles.
